// File: rtl/reg8to256.sv
// Byte-to-word packer: assembles NUM bytes (first byte in the MSB lane) into one
// wide word, with a one-word holding register and a flush for partial words.
module reg8to256 #(
  parameter int NUM   = 32,
  parameter int CNT_W = 6
) (
  input  logic               sclk,
  input  logic               srst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*NUM-1:0]   out_data,
  output logic [CNT_W-1:0]   out_cnt,
  output logic               out_last
);

  // Valid/ready: a byte moves when in_valid && in_ready, a word moves when
  // out_valid && out_ready; neither ready depends on its own valid.

  typedef enum logic {EMPTY, FULL} hold_t;

  hold_t              state;
  hold_t              state_next;
  logic [8*NUM-1:0]   acc;
  logic [8*NUM-1:0]   acc_new;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_new;
  logic               flush_pend;
  logic               flush_req;
  logic               accept;
  logic               can_load;
  logic               full_word;
  logic               flush_fire;
  logic               transfer;
  logic               pend_next;

  assign out_valid = (state == FULL);

  always_comb begin
    can_load  = (state == EMPTY) || out_ready;
    // The last slot may only be filled when the finished word has somewhere to go.
    in_ready  = !flush_pend && !(cnt == CNT_W'(NUM-1) && state == FULL && !out_ready);
    accept    = in_valid && in_ready;
    flush_req = flush || flush_pend;
    cnt_new   = cnt + CNT_W'(accept);
    acc_new   = acc;
    for (int k = 0; k < NUM; k++) begin
      if (accept && cnt == CNT_W'(k)) begin
        acc_new[8*(NUM-k)-1 -: 8] = in_data;
      end
    end
    full_word  = accept && (cnt == CNT_W'(NUM-1));
    flush_fire = flush_req && (cnt_new != '0) && can_load;
    transfer   = full_word || flush_fire;
    pend_next  = flush_req && (cnt_new != '0) && !transfer;
    state_next = state;
    if (transfer) begin
      state_next = FULL;
    end else if (state == FULL && out_ready) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge sclk) begin
    if (srst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge sclk) begin
    if (srst) begin
      acc        <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
      out_data   <= '0;
      out_cnt    <= '0;
      out_last   <= 1'b0;
    end else begin
      flush_pend <= pend_next;
      if (transfer) begin
        out_data <= acc_new;
        out_cnt  <= cnt_new;
        out_last <= flush_req;
        acc      <= '0;
        cnt      <= '0;
      end else begin
        acc <= acc_new;
        cnt <= cnt_new;
      end
    end
  end

endmodule

// File: tb/tb_reg8to256.sv
// Self-checking bench for reg8to256: directed scenarios plus random traffic,
// checked against a queue-based model of bytes, pending flush and held word.
module tb_reg8to256;

  localparam int NUM   = 32;
  localparam int CNT_W = 6;

  typedef logic [8*NUM+CNT_W:0] word_t;  // {last, cnt, data}

  logic               sclk;
  logic               srst;
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         in_data;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [8*NUM-1:0]   out_data;
  logic [CNT_W-1:0]   out_cnt;
  logic               out_last;

  int checks   = 0;
  int failures = 0;

  logic [7:0] cur[$];
  word_t      exp_q[$];
  logic       pend;

  reg8to256 #(.NUM(NUM), .CNT_W(CNT_W)) dut (
    .sclk(sclk), .srst(srst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_cnt(out_cnt), .out_last(out_last)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  function automatic logic model_ready(input logic ordy);
    return !pend && !(cur.size() == NUM-1 && exp_q.size() != 0 && !ordy);
  endfunction

  function automatic word_t make_word(input logic last);
    logic [8*NUM-1:0] d;
    d = '0;
    for (int k = 0; k < cur.size(); k++) d[8*(NUM-k)-1 -: 8] = cur[k];
    return {last, CNT_W'(cur.size()), d};
  endfunction

  task automatic model_edge(input logic iv, input logic [7:0] d, input logic fl,
                            input logic ordy, input logic rst, input logic rdy);
    logic freq;
    logic canload;
    if (rst) begin
      cur.delete();
      exp_q.delete();
      pend = 1'b0;
      return;
    end
    if (iv && rdy) cur.push_back(d);
    freq    = fl || pend;
    canload = (exp_q.size() == 0) || ordy;
    if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
    if (cur.size() == NUM) begin
      exp_q.push_back(make_word(freq));
      cur.delete();
      pend = 1'b0;
    end else if (freq && cur.size() != 0) begin
      if (canload) begin
        exp_q.push_back(make_word(1'b1));
        cur.delete();
        pend = 1'b0;
      end else begin
        pend = 1'b1;
      end
    end else begin
      pend = 1'b0;
    end
  endtask

  // Drives one cycle; returns observed and modelled in_ready for that cycle.
  task automatic step(input logic iv, input logic [7:0] d, input logic fl,
                      input logic ordy, input logic rst,
                      output logic rdy_obs, output logic rdy_exp);
    in_valid  = iv;
    in_data   = d;
    flush     = fl;
    out_ready = ordy;
    srst      = rst;
    #1;
    rdy_obs = in_ready;
    rdy_exp = model_ready(ordy);
    @(posedge sclk);
    model_edge(iv, d, fl, ordy, rst, rdy_exp);
    #1;
  endtask

  task automatic test_reset();
    logic ro, re;
    step(0, 8'h00, 0, 0, 1, ro, re);
    step(0, 8'h00, 0, 0, 1, ro, re);
    step(0, 8'h00, 0, 0, 0, ro, re);
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_cnt !== '0 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b c=%0d l=%b d=%h want all zero", out_valid, out_cnt, out_last, out_data);
    end
    checks++;
    if (ro !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got %b want 1", ro);
    end
  endtask

  task automatic test_full_word();
    logic ro, re;
    logic [8*NUM-1:0] w;
    for (int i = 0; i < NUM; i++) begin
      step(1, 8'(i), 0, 1, 0, ro, re);
      checks++;
      if (ro !== re) begin
        failures++;
        $display("FAIL full_word_in_ready byte %0d got %b want %b", i, ro, re);
      end
    end
    w = '0;
    for (int k = 0; k < NUM; k++) w[8*(NUM-k)-1 -: 8] = 8'(k);
    checks++;
    if (out_valid !== 1'b1 || out_data !== w || out_cnt !== 6'd32 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL full_word_out got v=%b c=%0d l=%b d=%h want v=1 c=32 l=0 d=%h", out_valid, out_cnt, out_last, out_data, w);
    end
    step(0, 8'h00, 0, 1, 0, ro, re);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_word_one_cycle got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic ro, re;
    int   n = 0;
    int   stalls = 0;
    int   cyc = 0;
    logic ordy;
    while (n < 2*NUM && cyc < 300) begin
      ordy = (stalls >= 3);
      step(1, 8'($urandom), 0, ordy, 0, ro, re);
      if (re) n++;
      else if (n == 2*NUM-1) stalls++;
      cyc++;
      checks++;
      if (ro !== re || out_valid !== (exp_q.size() != 0) ||
          (exp_q.size() != 0 && {out_last, out_cnt, out_data} !== exp_q[0])) begin
        failures++;
        $display("FAIL backpressure cyc %0d rdy=%b/%b got v=%b c=%0d l=%b d=%h want v=%b", cyc, ro, re, out_valid, out_cnt, out_last, out_data, exp_q.size() != 0);
      end
    end
    checks++;
    if (n != 2*NUM || stalls != 3) begin
      failures++;
      $display("FAIL backpressure_progress got bytes=%0d stalls=%0d want 64 and 3", n, stalls);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00, 0, 1, 0, ro, re);
      checks++;
      if (out_valid !== (exp_q.size() != 0) ||
          (exp_q.size() != 0 && {out_last, out_cnt, out_data} !== exp_q[0])) begin
        failures++;
        $display("FAIL backpressure_drain got v=%b c=%0d d=%h want v=%b", out_valid, out_cnt, out_data, exp_q.size() != 0);
      end
    end
  endtask

  task automatic test_flush();
    logic ro, re;
    logic [7:0] b [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    for (int i = 0; i < 5; i++) step(1, b[i], 0, 1, 0, ro, re);
    step(0, 8'h00, 1, 1, 0, ro, re);
    checks++;
    if (out_valid !== 1'b1 || out_data !== {40'hAABBCCDDEE, 216'h0} || out_cnt !== 6'd5 || out_last !== 1'b1) begin
      failures++;
      $display("FAIL flush_word got v=%b c=%0d l=%b d=%h want v=1 c=5 l=1", out_valid, out_cnt, out_last, out_data);
    end
    step(0, 8'h00, 1, 1, 0, ro, re);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_empty got v=%b want 0", out_valid);
    end
    step(0, 8'h00, 0, 1, 0, ro, re);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_empty_next got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush_with_byte();
    logic ro, re;
    int   words = 0;
    for (int i = 0; i < NUM-1; i++) step(1, 8'($urandom), 0, 1, 0, ro, re);
    step(1, 8'h55, 1, 1, 0, ro, re);
    checks++;
    if (out_valid !== 1'b1 || out_data[7:0] !== 8'h55 || out_cnt !== 6'd32 || out_last !== 1'b1 ||
        {out_last, out_cnt, out_data} !== exp_q[0]) begin
      failures++;
      $display("FAIL flush_byte_word got v=%b c=%0d l=%b d=%h want v=1 c=32 l=1 low=55", out_valid, out_cnt, out_last, out_data);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00, 0, 1, 0, ro, re);
      if (out_valid) words++;
    end
    checks++;
    if (words != 0) begin
      failures++;
      $display("FAIL flush_byte_single got extra words=%0d want 0", words);
    end
  endtask

  task automatic test_reset_mid();
    logic ro, re;
    logic [8*NUM-1:0] w;
    for (int i = 0; i < 10; i++) step(1, 8'($urandom), 0, 1, 0, ro, re);
    step(0, 8'h00, 0, 1, 1, ro, re);
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_cnt !== '0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_outputs got v=%b c=%0d l=%b rdy=%b d=%h want zeros rdy=1", out_valid, out_cnt, out_last, in_ready, out_data);
    end
    w = '0;
    for (int i = 0; i < NUM; i++) begin
      step(1, 8'(8'h80 + i), 0, 1, 0, ro, re);
      w[8*(NUM-i)-1 -: 8] = 8'(8'h80 + i);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== w || out_cnt !== 6'd32 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_word got v=%b c=%0d l=%b d=%h want %h", out_valid, out_cnt, out_last, out_data, w);
    end
    step(0, 8'h00, 0, 1, 0, ro, re);
  endtask

  task automatic test_blocked_flush();
    logic ro, re;
    for (int i = 0; i < NUM+3; i++) step(1, 8'($urandom), 0, 0, 0, ro, re);
    step(0, 8'h00, 1, 0, 0, ro, re);
    for (int i = 0; i < 4; i++) begin
      step(1, 8'($urandom), 0, 0, 0, ro, re);
      checks++;
      if (ro !== 1'b0 || re !== 1'b0) begin
        failures++;
        $display("FAIL blocked_flush_ready got %b want 0", ro);
      end
    end
    step(0, 8'h00, 0, 1, 0, ro, re);
    checks++;
    if (out_valid !== 1'b1 || out_cnt !== 6'd3 || out_last !== 1'b1 ||
        exp_q.size() != 1 || {out_last, out_cnt, out_data} !== exp_q[0]) begin
      failures++;
      $display("FAIL blocked_flush_word got v=%b c=%0d l=%b d=%h want v=1 c=3 l=1", out_valid, out_cnt, out_last, out_data);
    end
    step(0, 8'h00, 0, 1, 0, ro, re);
    checks++;
    if (out_valid !== 1'b0 || ro !== 1'b1) begin
      failures++;
      $display("FAIL blocked_flush_after got v=%b rdy=%b want v=0 rdy=1", out_valid, ro);
    end
  endtask

  task automatic test_random();
    logic ro, re;
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 9) < 6), 0, ro, re);
      checks++;
      if (ro !== re || out_valid !== (exp_q.size() != 0) ||
          (exp_q.size() != 0 && {out_last, out_cnt, out_data} !== exp_q[0])) begin
        failures++;
        $display("FAIL random cyc %0d rdy=%b/%b got v=%b c=%0d l=%b d=%h want v=%b", i, ro, re, out_valid, out_cnt, out_last, out_data, exp_q.size() != 0);
      end
    end
  endtask

  initial begin
    srst      = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    flush     = 1'b0;
    out_ready = 1'b0;
    pend      = 1'b0;
    @(posedge sclk);
    #1;
    test_reset();
    test_full_word();
    test_backpressure();
    test_flush();
    test_flush_with_byte();
    test_reset_mid();
    test_blocked_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
